// File: rtl/lsu_boot_loader_pkg.sv
// Shared types and defaults for the LSU boot loader.
// FSM state encoding, LSU funct code and window geometry.
package lsu_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0]  FUNC_SW       = 3'b010;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_2000;
  localparam int          DEF_MAX_WORDS = 2048;

endpackage

// File: rtl/lsu_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// o_word is valid (combinationally) on the cycle the 4th byte is taken.
module lsu_byte_packer
  import lsu_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_take,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_clr) begin
      r_cnt <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_take) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= {i_byte, r_sr[23:8]};
    end
  end

  // Earlier bytes sit low, the byte being taken lands in bits 31:24
  assign o_word       = {i_byte, r_sr};
  assign o_word_valid = i_take & (r_cnt == 2'd3);

endmodule

// File: rtl/lsu_boot_loader.sv
// Boot loader filling data memory through the LSU store port.
// Define LSU_BOOT_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module lsu_boot_loader
  import lsu_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_lsu_addr,
  output logic [2:0]            o_func,
  output logic                  o_lsu_wren,
  output logic [DATA_WIDTH-1:0] o_st_data,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_err
);

  state_t                r_state;
  logic [15:0]           r_len;
  logic [11:0]           r_idx;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_st_data;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic        w_ready;
  logic        w_hs;
  logic        w_take;
  logic        w_start_ok;
  logic        w_last;
  logic [15:0] w_n;
  logic [31:0] w_word;
  logic        w_word_valid;

  assign w_ready = (r_state == S_LEN0) | (r_state == S_LEN1) |
                   (r_state == S_DATA) | (r_state == S_CHK);
  assign w_hs       = i_byte_valid & w_ready;
  assign w_take     = w_hs & (r_state == S_DATA);
  assign w_start_ok = i_start & ((r_state == S_IDLE) |
                      (r_state == S_DONE) | (r_state == S_ERR));
  assign w_n        = {i_byte_data, r_len[7:0]};
  assign w_last     = ({4'd0, r_idx} + 16'd1) >= r_len;

  lsu_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (w_start_ok),
    .i_take       (w_take),
    .i_byte       (i_byte_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= 16'd0;
      r_idx     <= 12'd0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_st_data <= '0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      r_wren <= 1'b0;
      if (w_start_ok) begin
        r_state <= S_LEN0;
        r_idx   <= 12'd0;
        r_hold  <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
        r_csum  <= 8'd0;
`endif
      end else begin
        case (r_state)
          S_LEN0: begin
            if (w_hs) begin
              r_len[7:0] <= i_byte_data;
              r_state    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (w_hs) begin
              r_len <= w_n;
              if (w_n == 16'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else if (w_n > 16'(MAX_WORDS)) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
            if (w_take)
              r_csum <= r_csum ^ i_byte_data;
`endif
            if (w_word_valid) begin
              r_state   <= S_WRITE;
              r_wren    <= 1'b1;
              r_addr    <= BASE_ADDR + (ADDR_WIDTH'(r_idx) << 2);
              r_st_data <= DATA_WIDTH'(w_word);
            end
          end
          S_WRITE: begin
            r_idx <= r_idx + 12'd1;
            if (!w_last) begin
              r_state <= S_DATA;
            end else begin
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
`endif
            end
          end
`ifdef LSU_BOOT_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (w_hs) begin
              if (i_byte_data == r_csum) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_byte_ready = w_ready;
  assign o_lsu_addr   = r_addr;
  assign o_func       = FUNC_SW;
  assign o_lsu_wren   = r_wren;
  assign o_st_data    = r_st_data;
  assign o_cpu_hold   = r_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: doc/lsu_boot_loader.md
# lsu_boot_loader

Load/store initiator driving the LSU port (address, funct, write-enable, store-data) to fill data memory from a byte stream before the core runs. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and issues one store-word per word into the data-memory window starting at 0x2000. While loading, it holds the core in stall through `o_cpu_hold`.

## Interface
- ADDR_WIDTH, 32, LSU address width
- DATA_WIDTH, 32, LSU data width
- BASE_ADDR, 32'h0000_2000, address of first stored word
- MAX_WORDS, 2048, largest accepted length (8 KiB window 0x2000–0x3FFF)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse, begins a load
- i_byte_valid  in  1  stream byte valid
- i_byte_data  in  8  stream byte
- o_byte_ready  out  1  loader accepts a byte this cycle
- o_lsu_addr  out  ADDR_WIDTH  store address to LSU
- o_func  out  3  LSU funct code, constant 3'b010 (SW)
- o_lsu_wren  out  1  store strobe to LSU
- o_st_data  out  DATA_WIDTH  store data to LSU
- o_cpu_hold  out  1  core stall request
- o_done  out  1  load completed successfully (sticky)
- o_err  out  1  load aborted (sticky)

## Operation
- Stream: LEN_LO, LEN_HI (word count N, little-endian), then 4·N data bytes, each word little-endian (first byte → bits 7:0).
- States: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR + i_start → LEN0; clears o_done, o_err, word index, byte counter; sets o_cpu_hold.
- i_start in any other state is ignored.
- LEN0 → LEN1 on handshake; LEN1 → DATA on handshake.
- After LEN1: N == 0 → DONE (without CHK); N > MAX_WORDS → ERR; otherwise DATA.
- DATA: 2-bit byte counter; 4th accepted byte → WRITE.
- WRITE: o_lsu_wren = 1, o_lsu_addr = BASE_ADDR + 4·idx, o_st_data = packed word; idx increments. Next: DATA if idx+1 < N, else CHK (macro defined) or DONE.
- DONE: o_done = 1, o_cpu_hold = 0. ERR: o_err = 1, o_cpu_hold stays 1 until next i_start or reset.
- Index arithmetic: idx is 12 bits; address computed ADDR_WIDTH wide, no wrap possible since N ≤ MAX_WORDS.

## Timing
- Byte accepted on rising edge where i_byte_valid & o_byte_ready.
- o_byte_ready = 1 in LEN0, LEN1, DATA, CHK; 0 in IDLE, WRITE, DONE, ERR. A valid byte held during WRITE is accepted in the following DATA cycle.
- 4th byte edge → next cycle is WRITE; store commits on the edge closing WRITE. Minimum 5 cycles per word.
- o_lsu_wren high exactly one cycle per word; never in any other state.
- o_lsu_addr, o_st_data registered; hold last value outside WRITE.
- Reset values: state IDLE, o_byte_ready 0, o_lsu_addr 0, o_st_data 0, o_lsu_wren 0, o_cpu_hold 0, o_done 0, o_err 0, o_func 3'b010.
- Reset mid-load: immediate return to IDLE, wren drops asynchronously; already committed stores remain.

## Configuration
- LSU_BOOT_LOADER_CHECKSUM_EN defined: running XOR of all data bytes; CHK accepts one trailing byte; match → DONE, mismatch → ERR. Stores already issued are not undone.
- Undefined: no CHK state, no checksum byte; last WRITE → DONE; ERR only from length overflow.

## Structure
- Package lsu_boot_loader_pkg: state enum, FUNC_SW = 3'b010, default BASE_ADDR, MAX_WORDS.
- Sub-module lsu_byte_packer: byte counter + 32-bit little-endian shift/assemble register with word_valid pulse; FSM stays in lsu_boot_loader.

## Test plan
- i_start, bytes 01 00 EF BE AD DE → one cycle wren, addr 0x2000, data 0xDEADBEEF, then o_done=1, o_cpu_hold=0.
- N=2, bytes 01 02 03 04 05 06 07 08 → stores 0x04030201 @0x2000, 0x08070605 @0x2004; hold valid across WRITE, no byte lost.
- Length 00 00 → o_done=1 after 2nd byte, no wren pulse; length 01 08 (2049) → o_err=1, no wren, o_cpu_hold=1.
- Assert i_rst_n low after 2 data bytes → all outputs reset values next edge, no wren; new i_start reloads from 0x2000.
- Checksum on, N=1, bytes 11 22 33 44 then 44 → o_done; then 45 → o_err=1 (store 0x44332211 still issued).
- i_start pulsed during DATA → ignored, load completes normally.
